reg_dump: RTL and testbench

- Read-side companion to the 8-register file. It scans a contiguous (optionally wrapping) range of registers through one combinational read port and streams each value out over a valid/ready interface.
- After the data words it sends a trailing checksum word.
- Used for debug and test readout of processor state, and for shipping register contents to data memory or an external link.

---
 rtl/reg_dump_if.sv | 36 +++
 rtl/reg_dump.sv | 157 +++++++++++++++
 tb/tb_reg_dump.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_if.sv
// Register-dump bus: the combinational register-file read port plus the
// valid/ready output stream carrying register words and the trailing checksum.
interface reg_dump_if #(
  parameter int W = 8,
  parameter int D = 3
);
  // Read port toward the register file.
  logic [D-1:0] ReadReg;
  logic [W-1:0] ReadData;

  // Output word stream.
  logic [W-1:0] OutData;
  logic         OutValid;
  logic         OutReady;
  logic         OutLast;

  // The dump engine drives the read address and the stream.
  modport master (
    output ReadReg,
    input  ReadData,
    output OutData,
    output OutValid,
    input  OutReady,
    output OutLast
  );

  // The register file / consumer side.
  modport slave (
    input  ReadReg,
    output ReadData,
    input  OutData,
    input  OutValid,
    output OutReady,
    input  OutLast
  );
endinterface

// File: rtl/reg_dump.sv
// reg_dump: walks a contiguous, optionally wrapping, range of register indices
// through a single combinational read port and streams each value out over a
// valid/ready link, followed by a checksum word.  The checksum is chosen so
// that all streamed words, checksum included, add up to zero modulo 2**W.
// Each register is read in its own FETCH cycle, so the stream reflects
// register writes that land after Start but before that register's fetch.
module reg_dump #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic          CLK,
  input  logic          ResetN,
  input  logic          Start,
  input  logic [D-1:0]  FirstReg,
  input  logic [D-1:0]  LastReg,
  reg_dump_if.master    dump_bus,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_SUM   = 2'd3
  } state_t;

  localparam logic [D-1:0] ADDR_ONE = {{(D-1){1'b0}}, 1'b1};

  // Modular word addition used by the checksum accumulator.
  function automatic logic [W-1:0] f_add_mod(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    f_add_mod = a + b;
  endfunction

  // Two's-complement negation: the word that brings the running sum to zero.
  function automatic logic [W-1:0] f_neg_mod(input logic [W-1:0] a);
    f_neg_mod = '0 - a;
  endfunction

  state_t       r_state;
  logic [D-1:0] r_addr;
  logic [D-1:0] r_end;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_data;
  logic         r_done;

  state_t       w_state_nxt;
  logic [D-1:0] w_addr_nxt;
  logic [D-1:0] w_end_nxt;
  logic [W-1:0] w_acc_nxt;
  logic [W-1:0] w_data_nxt;
  logic         w_done_nxt;
  logic         w_out_valid;
  logic         w_out_last;
  logic         w_busy;
  logic         w_hs;

  // Next-state, datapath-next and output decode; every signal defaulted first.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_end_nxt   = r_end;
    w_acc_nxt   = r_acc;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_busy      = 1'b1;
    w_hs        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        // Start is only looked at here, so a Start while busy is dropped.
        if (Start) begin
          w_addr_nxt  = FirstReg;
          w_end_nxt   = LastReg;
          w_acc_nxt   = '0;
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        // Register value is sampled now, not at Start.
        w_data_nxt  = dump_bus.ReadData;
        w_state_nxt = S_SEND;
      end

      S_SEND: begin
        w_out_valid = 1'b1;
        w_hs        = dump_bus.OutReady;
        if (w_hs) begin
          w_acc_nxt = f_add_mod(r_acc, r_data);
          if (r_addr == r_end) begin
            // Last data word accepted: preload the checksum so it is
            // presented on the very next cycle.
            w_data_nxt  = f_neg_mod(f_add_mod(r_acc, r_data));
            w_state_nxt = S_SUM;
          end else begin
            // Counter wraps naturally at 2**D, giving the wrap-around range.
            w_addr_nxt  = r_addr + ADDR_ONE;
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_SUM: begin
        w_out_valid = 1'b1;
        w_out_last  = 1'b1;
        w_hs        = dump_bus.OutReady;
        if (w_hs) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any dump in progress.
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Address counter, end index, checksum accumulator, output word and Done.
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      r_addr <= '0;
      r_end  <= '0;
      r_acc  <= '0;
      r_data <= '0;
      r_done <= 1'b0;
    end else begin
      r_addr <= w_addr_nxt;
      r_end  <= w_end_nxt;
      r_acc  <= w_acc_nxt;
      r_data <= w_data_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign dump_bus.ReadReg  = r_addr;
  assign dump_bus.OutData  = r_data;
  assign dump_bus.OutValid = w_out_valid;
  assign dump_bus.OutLast  = w_out_last;
  assign Busy              = w_busy;
  assign Done              = r_done;

endmodule

// File: tb/tb_reg_dump.sv
// Testbench for reg_dump: directed dumps against a register-file array, with
// a transaction-level reference model checked on every falling edge plus
// hand-computed literal streams for each scenario.
module tb_reg_dump;
  localparam int W = 8;
  localparam int D = 3;

  logic         CLK = 1'b0;
  logic         ResetN;
  logic         Start;
  logic [D-1:0] FirstReg;
  logic [D-1:0] LastReg;
  logic         OutReady;
  logic         Busy;
  logic         Done;
  logic [W-1:0] mem [0:7];

  reg_dump_if #(.W(W), .D(D)) bus ();

  assign bus.ReadData = mem[bus.ReadReg];
  assign bus.OutReady = OutReady;

  reg_dump #(.W(W), .D(D)) dut (
    .CLK      (CLK),
    .ResetN   (ResetN),
    .Start    (Start),
    .FirstReg (FirstReg),
    .LastReg  (LastReg),
    .dump_bus (bus),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           mon_en = 1'b0;
  bit           m_busy = 1'b0;
  int           m_q[$];           // register indices still to be sent
  logic [W-1:0] m_sum = '0;       // sum of data words accepted so far
  bit           m_done_exp = 1'b0;
  int           cyc = 0;
  int           m_start_cyc = -100;
  bit           m_gap_chk = 1'b0;
  bit           m_gap_last = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  logic [W-1:0] got[$];           // every accepted word, in order
  logic [W-1:0] exp_q[$];

  always @(negedge CLK) begin
    logic [W-1:0] exp_w;
    bit           exp_last;
    bit           hs;
    bit           busy0;
    int           n;
    cyc++;
    if (mon_en) begin
      chk("busy", Busy, m_busy);
      chk("done", Done, m_done_exp);
      if (prev_stall) begin
        chk("hold_valid", bus.OutValid, 1'b1);
        chk("hold_data", bus.OutData, prev_data);
        chk("hold_last", bus.OutLast, prev_last);
      end
      if (m_gap_chk) chk("valid_after_hs", bus.OutValid, m_gap_last);
      if (cyc == m_start_cyc + 1) chk("fetch_no_valid", bus.OutValid, 1'b0);
      if (cyc == m_start_cyc + 2) chk("first_valid", bus.OutValid, 1'b1);
      if (bus.OutValid) begin
        chk("valid_while_busy", bus.OutValid, m_busy);
        exp_last = (m_q.size() == 0);
        chk("last_flag", bus.OutLast, exp_last);
        exp_w = exp_last ? (8'h00 - m_sum) : mem[m_q[0]];
        chk("word", bus.OutData, exp_w);
      end
    end

    // Events at the coming rising edge.
    hs         = ResetN && bus.OutValid && OutReady;
    busy0      = m_busy;
    m_gap_chk  = 1'b0;
    prev_stall = ResetN && bus.OutValid && !OutReady;
    prev_data  = bus.OutData;
    prev_last  = bus.OutLast;
    if (!ResetN) begin
      m_busy      = 1'b0;
      m_q.delete();
      m_done_exp  = 1'b0;
      m_start_cyc = -100;
    end else begin
      m_done_exp = hs && busy0 && (m_q.size() == 0);
      if (hs) begin
        got.push_back(bus.OutData);
        if (m_q.size() == 0) begin
          m_busy = 1'b0;
        end else begin
          m_sum = m_sum + mem[m_q[0]];
          void'(m_q.pop_front());
          m_gap_chk  = 1'b1;
          m_gap_last = (m_q.size() == 0);
        end
      end
      if (Start && !busy0) begin
        m_busy = 1'b1;
        m_q.delete();
        n = ((int'(LastReg) - int'(FirstReg)) & 7) + 1;
        for (int k = 0; k < n; k++) m_q.push_back((int'(FirstReg) + k) & 7);
        m_sum       = '0;
        m_start_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_dump(input int first, input int last);
    Start    = 1'b1;
    FirstReg = D'(first);
    LastReg  = D'(last);
    tick();
    Start    = 1'b0;
  endtask

  task automatic wait_got(input int n, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (got.size() >= n) break;
      tick();
    end
    chk("wait_words", got.size(), n);
  endtask

  task automatic chk_stream(input string nm);
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_w%0d", nm, i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] zsum;
    ResetN = 1'b0; Start = 1'b0; FirstReg = '0; LastReg = '0; OutReady = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
    repeat (3) tick();
    chk("rst_valid", bus.OutValid, 1'b0);
    chk("rst_data", bus.OutData, 8'h00);
    chk("rst_last", bus.OutLast, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_readreg", bus.ReadReg, 3'd0);
    ResetN = 1'b1;
    mon_en = 1'b1;
    tick();

    // Full dump 0..7
    got.delete();
    start_dump(0, 7);
    wait_got(9, 100);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h64};
    chk_stream("full");
    chk("full_done_pulse", Done, 1'b1);
    tick();
    chk("full_done_drop", Done, 1'b0);
    tick();

    // Wrapping range 6..1
    got.delete();
    start_dump(6, 1);
    wait_got(5, 100);
    exp_q = '{8'h16, 8'h17, 8'h10, 8'h11, 8'hB2};
    chk_stream("wrap");
    tick(); tick();

    // Single word
    got.delete();
    start_dump(3, 3);
    chk("single_busy", Busy, 1'b1);
    wait_got(2, 100);
    exp_q = '{8'h13, 8'hED};
    chk_stream("single");
    chk("single_done", Done, 1'b1);
    chk("single_idle", Busy, 1'b0);
    tick(); tick();

    // Backpressure on the second word
    got.delete();
    start_dump(0, 3);
    wait_got(1, 100);
    OutReady = 1'b0;
    tick();
    repeat (5) begin
      tick();
      chk("bp_valid", bus.OutValid, 1'b1);
      chk("bp_data", bus.OutData, 8'h11);
      chk("bp_addr", bus.ReadReg, 3'd1);
      chk("bp_count", got.size(), 1);
    end
    OutReady = 1'b1;
    wait_got(5, 100);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hBA};
    chk_stream("bp");
    tick(); tick();

    // Start while busy, then reset during SEND
    got.delete();
    start_dump(0, 7);
    wait_got(3, 100);
    Start = 1'b1; FirstReg = 3'd2; LastReg = 3'd2;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.OutValid) break;
      tick();
    end
    chk("pre_rst_valid", bus.OutValid, 1'b1);
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    chk("mid_rst_valid", bus.OutValid, 1'b0);
    chk("mid_rst_data", bus.OutData, 8'h00);
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_done", Done, 1'b0);
    repeat (3) begin
      tick();
      chk("post_rst_no_done", Done, 1'b0);
      chk("post_rst_no_valid", bus.OutValid, 1'b0);
    end
    got.delete();
    start_dump(0, 7);
    wait_got(9, 100);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h64};
    chk_stream("after_rst");
    tick(); tick();

    // Register write between Start and its fetch
    got.delete();
    start_dump(0, 7);
    mem[5] = 8'hAA;
    wait_got(9, 100);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'hAA, 8'h16, 8'h17, 8'hCF};
    chk_stream("fresh");
    zsum = '0;
    foreach (got[i]) zsum = zsum + got[i];
    chk("fresh_zero_sum", zsum, 8'h00);
    mem[5] = 8'h15;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
